// File: rtl/msg_byte_serializer.sv
// msg_byte_serializer
// Takes one whole message from the sequence parser over a valid/ready handshake.
// It sends that message out as a byte stream in index order, byte 0 first, and
// flags the final byte with byteOut_last. One message is buffered. The next
// message can be accepted on the same cycle the final byte leaves, so
// back-to-back traffic has no idle cycle between messages. Two saturating
// status counters record accepted messages and accepted lost packets.
//
// Ports:
//   clk           rising-edge clock
//   reset_b       asynchronous active-low reset
//   dataIn        message from parser, byte k = dataIn[8k:8k+7]
//   dataIn_val    message valid
//   dataIn_lost   packetLost flag, sampled together with dataIn
//   dataIn_ready  block can accept a message this cycle (combinational)
//   byteOut       current output byte
//   byteOut_val   byteOut valid
//   byteOut_last  byteOut is the final byte of its message
//   byteOut_lost  lost flag of the message being sent
//   byteOut_ready downstream accepts the current byte
//   statClear     synchronous clear of both counters
//   msgCount      messages accepted (saturating)
//   lostCount     accepted messages flagged lost (saturating)
module msg_byte_serializer #(
  parameter int MSG_BYTES = 37,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic [0:MSG_BYTES*8-1] dataIn,
  input  logic                   dataIn_val,
  input  logic                   dataIn_lost,
  output logic                   dataIn_ready,
  output logic [7:0]             byteOut,
  output logic                   byteOut_val,
  output logic                   byteOut_last,
  output logic                   byteOut_lost,
  input  logic                   byteOut_ready,
  input  logic                   statClear,
  output logic [CNT_W-1:0]       msgCount,
  output logic [CNT_W-1:0]       lostCount
);

  localparam int IDX_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // One-hot encoding so that an illegal value (00 or 11) can actually occur
  // and can be recovered from.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_SEND = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       buffer [MSG_BYTES];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             lost_q;
  logic             at_last;
  logic             accept;

  assign at_last = (idx == LAST_IDX);

  // Next-state logic and output decode.
  // dataIn_ready is gated by reset_b, so it reads 0 while reset is held.
  // In SEND, a new message can be accepted only when the final byte is being
  // taken on the same cycle. That is what gives zero-bubble back-to-back.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    dataIn_ready = 1'b0;
    byteOut      = 8'h00;
    byteOut_val  = 1'b0;
    byteOut_last = 1'b0;
    byteOut_lost = 1'b0;
    accept       = 1'b0;
    case (state)
      ST_IDLE: begin
        dataIn_ready = reset_b;
        accept       = dataIn_val & reset_b;
        if (accept) begin
          state_next = ST_SEND;
          idx_next   = '0;
        end
      end
      ST_SEND: begin
        byteOut_val  = 1'b1;
        byteOut      = buffer[idx];
        byteOut_last = at_last;
        byteOut_lost = lost_q;
        dataIn_ready = reset_b & at_last & byteOut_ready;
        accept       = dataIn_val & dataIn_ready;
        if (byteOut_ready) begin
          if (!at_last) begin
            idx_next = idx + IDX_W'(1);
          end else if (accept) begin
            idx_next = '0;
          end else begin
            state_next = ST_IDLE;
            idx_next   = '0;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // State, byte index, and the message buffer.
  // The buffer and the lost flag load only when a message is accepted.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state  <= ST_IDLE;
      idx    <= '0;
      lost_q <= 1'b0;
      for (int k = 0; k < MSG_BYTES; k++) begin
        buffer[k] <= 8'h00;
      end
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (accept) begin
        lost_q <= dataIn_lost;
        for (int k = 0; k < MSG_BYTES; k++) begin
          buffer[k] <= dataIn[8*k +: 8];
        end
      end
    end
  end

  // Status counters. If statClear arrives on the same cycle as an accept,
  // that accept is still counted, so the counter restarts at 1, not 0.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      msgCount  <= '0;
      lostCount <= '0;
    end else if (statClear) begin
      msgCount  <= accept ? CNT_ONE : '0;
      lostCount <= (accept && dataIn_lost) ? CNT_ONE : '0;
    end else if (accept) begin
      if (msgCount != CNT_MAX) begin
        msgCount <= msgCount + CNT_ONE;
      end
      if (dataIn_lost && (lostCount != CNT_MAX)) begin
        lostCount <= lostCount + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_msg_byte_serializer.sv
// tb_msg_byte_serializer
// Self-checking bench for msg_byte_serializer.
// Messages are kept as byte arrays. The expected byte stream, the handshake
// readiness, and the counters are all derived from those arrays and from
// simple counts of beats still owed. The counter width is set to 4 so that
// saturation is reachable quickly.
module tb_msg_byte_serializer;

  localparam int MSG_BYTES = 37;
  localparam int CNT_W     = 4;
  localparam int DW        = MSG_BYTES * 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_b = 1'b0;
  logic [0:DW-1]    dataIn = '0;
  logic             dataIn_val = 1'b0;
  logic             dataIn_lost = 1'b0;
  logic             dataIn_ready;
  logic [7:0]       byteOut;
  logic             byteOut_val;
  logic             byteOut_last;
  logic             byteOut_lost;
  logic             byteOut_ready = 1'b0;
  logic             statClear = 1'b0;
  logic [CNT_W-1:0] msgCount;
  logic [CNT_W-1:0] lostCount;

  typedef struct packed {
    logic                        lost;
    logic [MSG_BYTES-1:0][7:0]   b;
  } msg_t;

  msg_t       pend_q[$];
  msg_t       sent_q[$];
  logic [9:0] beat_q[$];
  logic [9:0] exp_q[$];
  int         beat_cyc[$];
  int         accept_cyc[$];
  logic [7:0] cyc_byte[$];
  logic       cyc_val[$];
  logic       cyc_bor[$];
  logic       cyc_dir[$];
  int         cyc_flight[$];

  int ready_mode;
  bit val_gaps;
  int msg_exp;
  int lost_exp;
  int checks;
  int errors;

  msg_byte_serializer #(.MSG_BYTES(MSG_BYTES), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .dataIn       (dataIn),
    .dataIn_val   (dataIn_val),
    .dataIn_lost  (dataIn_lost),
    .dataIn_ready (dataIn_ready),
    .byteOut      (byteOut),
    .byteOut_val  (byteOut_val),
    .byteOut_last (byteOut_last),
    .byteOut_lost (byteOut_lost),
    .byteOut_ready(byteOut_ready),
    .statClear    (statClear),
    .msgCount     (msgCount),
    .lostCount    (lostCount)
  );

  always #5 clk = ~clk;

  // Build the wire image by shifting bytes in, so byte 0 ends up first.
  function automatic logic [0:DW-1] pack_msg(input msg_t m);
    logic [0:DW-1] d = '0;
    for (int k = 0; k < MSG_BYTES; k++) d = {d[8:DW-1], m.b[k]};
    return d;
  endfunction

  function automatic msg_t rand_msg(input logic lost);
    msg_t m;
    m.lost = lost;
    for (int k = 0; k < MSG_BYTES; k++) m.b[k] = 8'($urandom);
    return m;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Expected beats {lost, last, byte} for every accepted message, in order.
  function automatic void build_expected();
    exp_q.delete();
    foreach (sent_q[i])
      for (int k = 0; k < MSG_BYTES; k++)
        exp_q.push_back({sent_q[i].lost, (k == MSG_BYTES - 1), sent_q[i].b[k]});
  endfunction

  // Offers every message in pend_q and logs what the DUT shows on each cycle.
  // Runs until all accepted messages have been fully drained.
  // ready_mode: 0 always ready, 1 random, 2 stall twice on byte 5.
  task automatic run_traffic(input int max_cycles, output bit timed_out);
    int   n_acc  = 0;
    int   beats  = 0;
    int   stalls = 0;
    int   c      = 0;
    int   flight;
    logic bor;
    logic offer;
    sent_q.delete(); beat_q.delete(); beat_cyc.delete(); accept_cyc.delete();
    cyc_byte.delete(); cyc_val.delete(); cyc_bor.delete(); cyc_dir.delete();
    cyc_flight.delete();
    timed_out = 1'b0;
    while (!(pend_q.size() == 0 && beats == n_acc * MSG_BYTES)) begin
      if (c >= max_cycles) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      flight = n_acc * MSG_BYTES - beats;
      offer  = (pend_q.size() > 0) && !(val_gaps && $urandom_range(0, 3) == 0);
      dataIn_val  = offer;
      dataIn      = offer ? pack_msg(pend_q[0]) : '0;
      dataIn_lost = offer ? pend_q[0].lost : 1'b0;
      case (ready_mode)
        1: bor = 1'($urandom_range(0, 1));
        2: begin
          bor = 1'b1;
          if (flight > 0 && (beats % MSG_BYTES) == 5 && stalls < 2) begin
            bor = 1'b0;
            stalls++;
          end
        end
        default: bor = 1'b1;
      endcase
      byteOut_ready = bor;
      #1;
      cyc_byte.push_back(byteOut);
      cyc_val.push_back(byteOut_val);
      cyc_bor.push_back(bor);
      cyc_dir.push_back(dataIn_ready);
      cyc_flight.push_back(flight);
      if (byteOut_val && byteOut_ready) begin
        beat_q.push_back({byteOut_lost, byteOut_last, byteOut});
        beat_cyc.push_back(c);
        beats++;
      end
      if (dataIn_val && dataIn_ready) begin
        accept_cyc.push_back(c);
        lost_exp = pend_q[0].lost ? sat_inc(lost_exp) : lost_exp;
        msg_exp  = sat_inc(msg_exp);
        sent_q.push_back(pend_q.pop_front());
        n_acc++;
      end
      c++;
    end
    @(negedge clk);
    dataIn_val = 1'b0; dataIn = '0; dataIn_lost = 1'b0; byteOut_ready = 1'b0;
  endtask

  task automatic clear_counters();
    @(negedge clk); statClear = 1'b1;
    @(negedge clk); statClear = 1'b0;
    msg_exp = 0; lost_exp = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (dataIn_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got %b want 0", dataIn_ready); end
    checks++; if (byteOut_val !== 1'b0 || byteOut_last !== 1'b0 || byteOut !== 8'h00) begin errors++; $display("[TB] FAIL rst_out got val=%b last=%b byte=%h want 0/0/00", byteOut_val, byteOut_last, byteOut); end
    checks++; if (msgCount !== '0 || lostCount !== '0) begin errors++; $display("[TB] FAIL rst_cnt got %0d/%0d want 0/0", msgCount, lostCount); end
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    #1;
    checks++; if (dataIn_ready !== 1'b1 || byteOut_val !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle got ready=%b val=%b want 1/0", dataIn_ready, byteOut_val); end
  endtask

  task automatic test_single();
    msg_t m;
    bit   to;
    m.lost = 1'b0;
    for (int k = 0; k < MSG_BYTES; k++) m.b[k] = 8'(k + 1);
    pend_q.push_back(m);
    ready_mode = 0; val_gaps = 0;
    run_traffic(200, to);
    build_expected();
    checks++; if (to) begin errors++; $display("[TB] FAIL single_timeout got timeout want drained"); end
    checks++; if (beat_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL single_count got %0d want %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL single_beat%0d got %h want %h", i, beat_q[i], exp_q[i]); end
    end
    if (beat_cyc.size() == MSG_BYTES && accept_cyc.size() == 1) begin
      checks++; if (beat_cyc[0] != accept_cyc[0] + 1) begin errors++; $display("[TB] FAIL single_latency got %0d want %0d", beat_cyc[0], accept_cyc[0] + 1); end
      checks++; if (beat_cyc[MSG_BYTES-1] != beat_cyc[0] + MSG_BYTES - 1) begin errors++; $display("[TB] FAIL single_span got %0d want %0d", beat_cyc[MSG_BYTES-1], beat_cyc[0] + MSG_BYTES - 1); end
    end
    checks++; if (msgCount !== CNT_W'(msg_exp) || lostCount !== CNT_W'(lost_exp)) begin errors++; $display("[TB] FAIL single_cnt got %0d/%0d want %0d/%0d", msgCount, lostCount, msg_exp, lost_exp); end
  endtask

  task automatic test_back_to_back();
    bit to;
    pend_q.push_back(rand_msg(1'b0));
    pend_q.push_back(rand_msg(1'b0));
    ready_mode = 0; val_gaps = 0;
    run_traffic(300, to);
    build_expected();
    checks++; if (to) begin errors++; $display("[TB] FAIL b2b_timeout got timeout want drained"); end
    checks++; if (beat_q.size() != 2 * MSG_BYTES) begin errors++; $display("[TB] FAIL b2b_count got %0d want %0d", beat_q.size(), 2 * MSG_BYTES); end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_beat%0d got %h want %h", i, beat_q[i], exp_q[i]); end
      checks++; if (beat_cyc[i] != beat_cyc[0] + i) begin errors++; $display("[TB] FAIL b2b_gap%0d got cycle %0d want %0d", i, beat_cyc[i], beat_cyc[0] + i); end
    end
    if (accept_cyc.size() == 2 && beat_cyc.size() >= MSG_BYTES) begin
      checks++; if (accept_cyc[1] != beat_cyc[MSG_BYTES-1]) begin errors++; $display("[TB] FAIL b2b_accept got cycle %0d want %0d", accept_cyc[1], beat_cyc[MSG_BYTES-1]); end
    end
    checks++; if (msgCount !== CNT_W'(msg_exp)) begin errors++; $display("[TB] FAIL b2b_cnt got %0d want %0d", msgCount, msg_exp); end
  endtask

  task automatic test_stall();
    msg_t m;
    bit   to;
    int   n_stall = 0;
    m = rand_msg(1'b0);
    pend_q.push_back(m);
    ready_mode = 2; val_gaps = 0;
    run_traffic(200, to);
    build_expected();
    checks++; if (to) begin errors++; $display("[TB] FAIL stall_timeout got timeout want drained"); end
    for (int i = 0; i < cyc_val.size(); i++) begin
      if (cyc_val[i] && !cyc_bor[i]) begin
        n_stall++;
        checks++; if (cyc_byte[i] !== m.b[5] || cyc_dir[i] !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold%0d got byte=%h ready=%b want %h/0", i, cyc_byte[i], cyc_dir[i], m.b[5]); end
      end
    end
    checks++; if (n_stall != 2) begin errors++; $display("[TB] FAIL stall_cycles got %0d want 2", n_stall); end
    checks++; if (beat_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL stall_count got %0d want %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL stall_beat%0d got %h want %h", i, beat_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_lost_flag();
    bit to;
    clear_counters();
    #1;
    checks++; if (msgCount !== '0 || lostCount !== '0) begin errors++; $display("[TB] FAIL clear_cnt got %0d/%0d want 0/0", msgCount, lostCount); end
    pend_q.push_back(rand_msg(1'b1));
    pend_q.push_back(rand_msg(1'b0));
    ready_mode = 1; val_gaps = 0;
    run_traffic(1000, to);
    build_expected();
    checks++; if (to) begin errors++; $display("[TB] FAIL lost_timeout got timeout want drained"); end
    checks++; if (beat_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL lost_count got %0d want %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL lost_beat%0d got %h want %h", i, beat_q[i], exp_q[i]); end
    end
    checks++; if (msgCount !== 4'd2 || lostCount !== 4'd1) begin errors++; $display("[TB] FAIL lost_cnt got %0d/%0d want 2/1", msgCount, lostCount); end
  endtask

  task automatic test_saturation();
    bit   to;
    msg_t m;
    int   n = 0;
    clear_counters();
    for (int i = 0; i < 17; i++) pend_q.push_back(rand_msg(1'b1));
    ready_mode = 1; val_gaps = 1;
    run_traffic(5000, to);
    build_expected();
    checks++; if (to) begin errors++; $display("[TB] FAIL sat_timeout got timeout want drained"); end
    checks++; if (beat_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL sat_count got %0d want %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL sat_beat%0d got %h want %h", i, beat_q[i], exp_q[i]); end
    end
    // Ready whenever nothing is owed, or only the last byte is owed and it is being taken now.
    for (int i = 0; i < cyc_dir.size(); i++) begin
      checks++;
      if (cyc_dir[i] !== ((cyc_flight[i] == 0) || (cyc_flight[i] == 1 && cyc_bor[i])) || cyc_val[i] !== (cyc_flight[i] > 0)) begin
        errors++; $display("[TB] FAIL sat_hs%0d got ready=%b val=%b with %0d owed", i, cyc_dir[i], cyc_val[i], cyc_flight[i]);
      end
    end
    checks++; if (msgCount !== 4'd15 || lostCount !== 4'd15) begin errors++; $display("[TB] FAIL sat_cnt got %0d/%0d want 15/15", msgCount, lostCount); end
    m = rand_msg(1'b1);
    @(negedge clk);
    dataIn = pack_msg(m); dataIn_lost = 1'b1; dataIn_val = 1'b1; statClear = 1'b1; byteOut_ready = 1'b1;
    #1;
    checks++; if (dataIn_ready !== 1'b1) begin errors++; $display("[TB] FAIL clracc_ready got %b want 1", dataIn_ready); end
    @(negedge clk);
    dataIn_val = 1'b0; statClear = 1'b0; dataIn = '0; dataIn_lost = 1'b0;
    msg_exp = 1; lost_exp = 1;
    #1;
    checks++; if (msgCount !== 4'd1 || lostCount !== 4'd1) begin errors++; $display("[TB] FAIL clracc_cnt got %0d/%0d want 1/1", msgCount, lostCount); end
    for (int i = 0; i < 60 && n < MSG_BYTES; i++) begin
      if (byteOut_val) begin
        checks++; if (byteOut !== m.b[n]) begin errors++; $display("[TB] FAIL clracc_beat%0d got %h want %h", n, byteOut, m.b[n]); end
        n++;
      end
      @(negedge clk); #1;
    end
    checks++; if (n != MSG_BYTES) begin errors++; $display("[TB] FAIL clracc_drain got %0d beats want %0d", n, MSG_BYTES); end
    byteOut_ready = 1'b0;
  endtask

  task automatic test_reset_mid_message();
    msg_t m;
    bit   to;
    m = rand_msg(1'b1);
    @(negedge clk);
    dataIn = pack_msg(m); dataIn_lost = 1'b1; dataIn_val = 1'b1; byteOut_ready = 1'b1;
    #1;
    checks++; if (dataIn_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ready got %b want 1", dataIn_ready); end
    @(negedge clk);
    dataIn_val = 1'b0; dataIn = '0; dataIn_lost = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (byteOut_val !== 1'b1 || byteOut !== m.b[20]) begin errors++; $display("[TB] FAIL rmid_byte20 got val=%b byte=%h want 1/%h", byteOut_val, byteOut, m.b[20]); end
    #1 reset_b = 1'b0;
    #1;
    msg_exp = 0; lost_exp = 0;
    checks++; if (byteOut_val !== 1'b0 || byteOut_last !== 1'b0 || dataIn_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_async got val=%b last=%b ready=%b want 0/0/0", byteOut_val, byteOut_last, dataIn_ready); end
    checks++; if (msgCount !== '0 || lostCount !== '0) begin errors++; $display("[TB] FAIL rmid_cnt got %0d/%0d want 0/0", msgCount, lostCount); end
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    #1;
    checks++; if (dataIn_ready !== 1'b1 || byteOut_val !== 1'b0) begin errors++; $display("[TB] FAIL rmid_idle got ready=%b val=%b want 1/0", dataIn_ready, byteOut_val); end
    pend_q.push_back(rand_msg(1'b0));
    ready_mode = 0; val_gaps = 0;
    run_traffic(200, to);
    build_expected();
    checks++; if (to) begin errors++; $display("[TB] FAIL rmid_timeout got timeout want drained"); end
    checks++; if (beat_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rmid_count got %0d want %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rmid_beat%0d got %h want %h", i, beat_q[i], exp_q[i]); end
    end
    checks++; if (msgCount !== CNT_W'(msg_exp) || lostCount !== CNT_W'(lost_exp)) begin errors++; $display("[TB] FAIL rmid_cnt2 got %0d/%0d want %0d/%0d", msgCount, lostCount, msg_exp, lost_exp); end
  endtask

  initial begin
    checks = 0; errors = 0; msg_exp = 0; lost_exp = 0;
    ready_mode = 0; val_gaps = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_lost_flag();
    test_saturation();
    test_reset_mid_message();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit in case the DUT stops responding somewhere unbounded.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no completion want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/msg_byte_serializer.md
Name: msg_byte_serializer

Overview:
Sits directly downstream of the sequence parser and consumes its 296-bit message (37 bytes) plus the per-message packetLost flag through a valid/ready handshake. It serialises each message into a byte stream in index order and marks the final byte with a last flag. It also keeps saturating message and lost-packet counters for status readout. One message is buffered internally, and back-to-back messages are accepted without a bubble.

Parameters:
MSG_BYTES, 37, bytes per message; the dataIn width is MSG_BYTES*8.
CNT_W, 16, width of the msgCount and lostCount status counters.

Ports:
clk  input  1  clock, all logic on rising edge
reset_b  input  1  asynchronous active-low reset
dataIn  input  [0:MSG_BYTES*8-1]  message from parser; byte k = dataIn[8k:8k+7]
dataIn_val  input  1  message valid
dataIn_lost  input  1  packetLost flag, sampled with dataIn
dataIn_ready  output  1  block can accept a message this cycle
byteOut  output  8  current output byte
byteOut_val  output  1  byteOut valid
byteOut_last  output  1  byteOut is byte MSG_BYTES-1 of the message
byteOut_lost  output  1  lost flag of the message being sent, held for all its bytes
byteOut_ready  input  1  downstream accepts byte
statClear  input  1  synchronous pulse that clears both counters
msgCount  output  CNT_W  messages accepted, saturating
lostCount  output  CNT_W  accepted messages with dataIn_lost=1, saturating

Behaviour:
- Reset (async assert, sync release): state=IDLE; buffer, byte index and all outputs 0; dataIn_ready=0 while reset_b=0.
- States and transitions:
  - IDLE: dataIn_ready=1 and byteOut_val=0. On dataIn_val&dataIn_ready, latch dataIn, latch the lost flag, set idx=0 and go to SEND.
  - SEND: byteOut_val=1, byteOut=buffer byte idx, byteOut_last=(idx==MSG_BYTES-1).
- Byte accept in SEND (byteOut_val&byteOut_ready):
  - If idx<MSG_BYTES-1: idx+1.
  - If idx==MSG_BYTES-1: if a new message is accepted the same cycle, reload the buffer, set idx=0 and stay in SEND; otherwise go to IDLE.
- dataIn_ready = IDLE | (SEND & idx==MSG_BYTES-1 & byteOut_ready). This is combinational and gives zero-bubble back-to-back operation.
- Latency: message accepted at edge N; byte 0 is valid after edge N. A full message takes MSG_BYTES accepted beats.
- Stall: while byteOut_ready=0, byteOut, byteOut_last, byteOut_lost and byteOut_val hold stable. byteOut_val never drops mid-message.
- dataIn is not sampled unless dataIn_ready=1. The parser's zeroed dataOut when not valid is irrelevant.
- Counters, updated on message accept:
  - msgCount increments by 1 on every accept.
  - lostCount increments by 1 on accept with dataIn_lost=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- statClear: counters go to 0 next edge. If an accept coincides with statClear, the counter becomes 1 (lostCount becomes 1 only if lost=1).
- Reset mid-message: partial message discarded; no last emitted; counters 0.
- Only these two states exist; an illegal state encoding recovers to IDLE next cycle.

Test Plan:
1. Single message, dataIn byte k = k+1, lost=0, byteOut_ready=1 -> bytes 0x01..0x25 on 37 consecutive cycles starting one cycle after accept; last only on 0x25; byteOut_lost=0; msgCount=1, lostCount=0.
2. Two messages presented back-to-back, byteOut_ready=1 -> second accepted on the cycle of the first's last byte; 74 consecutive valid beats with no gap; msgCount=2.
3. byteOut_ready toggling 1,0,0,1 during bytes 5..6 -> byte 5 held stable for 2 stalled cycles; no byte dropped or duplicated; dataIn_ready=0 throughout.
4. Message with lost=1, then message with lost=0 -> byteOut_lost=1 on all 37 bytes of the first message and 0 on the second; lostCount=1, msgCount=2.
5. CNT_W=4, 17 messages with lost=1 -> both counters saturate at 15; statClear together with an 18th accept -> msgCount=1, lostCount=1.
6. reset_b pulsed low at byte 20 -> byteOut_val=0 asynchronously; after release, state is IDLE with dataIn_ready=1; a new message then starts at byte 0.
